vga_pixel_sink: RTL and testbench

//  Receiving end of the game's VGA pixel-write stream (colour/coordinates/write-enable as muxed by the game datapath).

---
 rtl/vga_pixel_sink.sv | 181 ++++++++++++++++++
 tb/tb_vga_pixel_sink.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_pixel_sink.sv
// VGA pixel-write sink: range check, FIFO, frame-buffer writer, clear sweep.
// Define PIXEL_STATS_EN to build the written/dropped statistics counters.
module vga_pixel_sink #(
  parameter int FIFO_DEPTH = 8,
  parameter int SCR_W      = 160,
  parameter int SCR_H      = 120
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        pix_we,
  input  logic [8:0]  pix_colour,
  input  logic [14:0] pix_coord,
  input  logic        clear_req,
  input  logic [8:0]  clear_colour,
  output logic [14:0] fb_addr,
  output logic [8:0]  fb_data,
  output logic        fb_wren,
  output logic        fifo_full,
  output logic        overflow,
  output logic        clear_busy,
  output logic        clear_done,
  output logic [15:0] stat_written,
  output logic [15:0] stat_dropped
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);
  localparam logic [7:0] W8 = 8'(SCR_W);
  localparam logic [6:0] H7 = 7'(SCR_H);
  localparam logic [14:0] FB_LAST = 15'(SCR_W*SCR_H-1);

  typedef enum logic [1:0] {
    IDLE,
    DRAIN,
    CLEAR,
    DONE
  } state_t;

  state_t state;

  logic [23:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;

  logic [7:0]  px;
  logic [6:0]  py;
  logic [14:0] pix_addr;
  logic        in_range;
  logic        empty;
  logic        start_clr;
  logic        pop;
  logic        push;
  logic        ov_drop;

  logic [14:0] clr_addr;
  logic [8:0]  clr_colour;

  assign px = pix_coord[14:7];
  assign py = pix_coord[6:0];
  assign in_range = (px < W8) && (py < H7);
  // y*160 + x as y*128 + y*32 + x
  assign pix_addr = {1'b0, py, 7'b0}
                  + {3'b0, py, 5'b0}
                  + {7'b0, px};

  assign empty = (count == '0);
  assign fifo_full = (count == FULL_CNT);
  assign start_clr = clear_req
                  && (state == IDLE || state == DRAIN);
  assign pop = !empty && !start_clr
            && (state == IDLE || state == DRAIN);
  // a flush or a same-cycle pop makes room in a full FIFO
  assign push = pix_we && in_range
             && (!fifo_full || pop || start_clr);
  assign ov_drop = pix_we && in_range && !push;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {pix_addr, pix_colour};
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (start_clr) begin
      rd_ptr <= wr_ptr;
      wr_ptr <= wr_ptr + AW'(push);
      count  <= (AW+1)'(push);
    end else begin
      wr_ptr <= wr_ptr + AW'(push);
      rd_ptr <= rd_ptr + AW'(pop);
      count  <= count + (AW+1)'(push)
              - (AW+1)'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state      <= IDLE;
      fb_addr    <= '0;
      fb_data    <= '0;
      fb_wren    <= 1'b0;
      overflow   <= 1'b0;
      clear_busy <= 1'b0;
      clear_done <= 1'b0;
      clr_addr   <= '0;
      clr_colour <= '0;
    end else begin
      fb_wren    <= 1'b0;
      clear_done <= 1'b0;
      if (ov_drop) overflow <= 1'b1;
      if (pop) begin
        {fb_addr, fb_data} <= mem[rd_ptr];
        fb_wren <= 1'b1;
      end
      unique case (state)
        IDLE: begin
          if (start_clr) begin
            state      <= CLEAR;
            clr_colour <= clear_colour;
            clr_addr   <= '0;
            clear_busy <= 1'b1;
          end else if (!empty) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          if (start_clr) begin
            state      <= CLEAR;
            clr_colour <= clear_colour;
            clr_addr   <= '0;
            clear_busy <= 1'b1;
          end else if (empty) begin
            state <= IDLE;
          end
        end
        CLEAR: begin
          fb_addr  <= clr_addr;
          fb_data  <= clr_colour;
          fb_wren  <= 1'b1;
          clr_addr <= clr_addr + 15'd1;
          if (clr_addr == FB_LAST) state <= DONE;
        end
        DONE: begin
          clear_done <= 1'b1;
          clear_busy <= 1'b0;
          state      <= IDLE;
        end
      endcase
    end
  end

`ifdef PIXEL_STATS_EN
  logic        range_drop;
  logic [15:0] n_written;
  logic [15:0] n_dropped;

  assign range_drop = pix_we && !in_range;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      n_written <= '0;
      n_dropped <= '0;
    end else begin
      if (pop && !(&n_written))
        n_written <= n_written + 16'd1;
      if ((range_drop || ov_drop) && !(&n_dropped))
        n_dropped <= n_dropped + 16'd1;
    end
  end

  assign stat_written = n_written;
  assign stat_dropped = n_dropped;
`else
  assign stat_written = '0;
  assign stat_dropped = '0;
`endif

endmodule

// File: tb/tb_vga_pixel_sink.sv
// Self-checking bench for vga_pixel_sink.
// Scoreboard of pixel writes plus a tracker for clear sweeps.
module tb_vga_pixel_sink;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        pix_we = 1'b0;
  logic [8:0]  pix_colour = '0;
  logic [14:0] pix_coord = '0;
  logic        clear_req = 1'b0;
  logic [8:0]  clear_colour = '0;
  logic [14:0] fb_addr;
  logic [8:0]  fb_data;
  logic        fb_wren;
  logic        fifo_full;
  logic        overflow;
  logic        clear_busy;
  logic        clear_done;
  logic [15:0] stat_written;
  logic [15:0] stat_dropped;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  vga_pixel_sink dut (
    .clk(clk),
    .resetn(resetn),
    .pix_we(pix_we),
    .pix_colour(pix_colour),
    .pix_coord(pix_coord),
    .clear_req(clear_req),
    .clear_colour(clear_colour),
    .fb_addr(fb_addr),
    .fb_data(fb_data),
    .fb_wren(fb_wren),
    .fifo_full(fifo_full),
    .overflow(overflow),
    .clear_busy(clear_busy),
    .clear_done(clear_done),
    .stat_written(stat_written),
    .stat_dropped(stat_dropped)
  );

  typedef struct {
    int          x;
    int          y;
    logic [8:0]  c;
    logic        ok;
    logic [14:0] addr;
  } vec_t;

  vec_t tbl[10];

  logic [23:0] exp_q[$];
  int cyc = 0;
  int clr_next = 0;
  int clr_bad = 0;
  logic [8:0] clr_col = '0;
  int n_wr = 0;
  int n_drop = 0;
  int wr_first = -1;
  int wr_last = -1;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d",
               name, act, req);
    end
  endtask

  function automatic logic [31:0] st(input int v);
`ifdef PIXEL_STATS_EN
    return v;
`else
    return (v == -1) ? 32'd1 : 32'd0;
`endif
  endfunction

  always @(negedge clk) begin
    logic [23:0] e;
    cyc++;
    if (fb_wren && clear_busy) begin
      if (fb_addr != 15'(clr_next) || fb_data != clr_col)
        clr_bad++;
      clr_next++;
    end else if (fb_wren) begin
      n_wr++;
      if (wr_first < 0) wr_first = cyc;
      wr_last = cyc;
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_write: addr %0d data %0h",
                 fb_addr, fb_data);
      end else begin
        e = exp_q.pop_front();
        check("pix_write", {8'b0, fb_addr, fb_data},
              {8'b0, e});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int x, input int y,
                       input logic [8:0] c);
    pix_we = 1'b1;
    pix_coord = {8'(x), 7'(y)};
    pix_colour = c;
  endtask

  task automatic exp_push(input int x, input int y,
                          input logic [8:0] c);
    exp_q.push_back({15'(y * 160 + x), c});
  endtask

  task automatic send(input int x, input int y,
                      input logic [8:0] c);
    drive(x, y, c);
    tick();
    pix_we = 1'b0;
  endtask

  task automatic drain(input string name, input int budget);
    int i;
    for (i = 0; i < budget && exp_q.size() != 0; i++) tick();
    check(name, exp_q.size(), 0);
    tick();
    tick();
  endtask

  task automatic wait_done(input string name);
    int i;
    for (i = 0; i < 20000 && !clear_done; i++) tick();
    check(name, clear_done, 1);
  endtask

  initial begin
    int x;
    int y;
    int wr_before;
    int i;

    tbl[0] = '{0, 0, 9'h001, 1'b1, 15'd0};
    tbl[1] = '{159, 119, 9'h1FF, 1'b1, 15'd19199};
    tbl[2] = '{255, 127, 9'h0F0, 1'b0, 15'd0};
    tbl[3] = '{1, 1, 9'h00F, 1'b1, 15'd161};
    tbl[4] = '{159, 120, 9'h0AA, 1'b0, 15'd0};
    tbl[5] = '{2, 2, 9'h155, 1'b1, 15'd322};
    tbl[6] = '{159, 0, 9'h038, 1'b1, 15'd159};
    tbl[7] = '{0, 119, 9'h007, 1'b1, 15'd19040};
    tbl[8] = '{200, 50, 9'h100, 1'b0, 15'd0};
    tbl[9] = '{80, 60, 9'h0C3, 1'b1, 15'd9680};

    tick();
    tick();
    check("rst_wren", fb_wren, 0);
    check("rst_addr", fb_addr, 0);
    check("rst_data", fb_data, 0);
    check("rst_full", fifo_full, 0);
    check("rst_ovf", overflow, 0);
    check("rst_busy", clear_busy, 0);
    check("rst_done", clear_done, 0);
    check("rst_stw", stat_written, 0);
    check("rst_std", stat_dropped, 0);
    resetn = 1'b1;
    tick();

    exp_push(10, 5, 9'h1C0);
    send(10, 5, 9'h1C0);
    check("lat_edge_n", fb_wren, 0);
    tick();
    check("lat_wren", fb_wren, 1);
    check("lat_addr", fb_addr, 810);
    check("lat_data", fb_data, 9'h1C0);
    tick();
    check("hold_wren", fb_wren, 0);
    check("hold_addr", fb_addr, 810);
    check("hold_data", fb_data, 9'h1C0);
    drain("drain_t1", 10);

    send(160, 0, 9'h1FF);
    send(0, 120, 9'h1FF);
    n_drop += 2;
    tick();
    tick();
    check("range_stat", stat_dropped, st(n_drop));

    for (i = 0; i < 10; i++) begin
      if (tbl[i].ok)
        exp_q.push_back({tbl[i].addr, tbl[i].c});
      else
        n_drop++;
      send(tbl[i].x, tbl[i].y, tbl[i].c);
    end
    drain("drain_tbl", 20);
    check("tbl_stat_drop", stat_dropped, st(n_drop));
    check("tbl_ovf", overflow, 0);

    wr_first = -1;
    for (i = 0; i < 20; i++) begin
      x = $urandom_range(159, 0);
      y = $urandom_range(119, 0);
      exp_push(x, y, 9'(i + 3));
      drive(x, y, 9'(i + 3));
      tick();
    end
    pix_we = 1'b0;
    drain("drain_burst", 30);
    check("burst_span", wr_last - wr_first, 19);
    check("burst_ovf", overflow, 0);
    check("burst_full", fifo_full, 0);
    check("burst_stw", stat_written, st(n_wr));

    clr_next = 0;
    clr_bad = 0;
    clr_col = 9'h000;
    clear_colour = 9'h000;
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    check("clr_busy_on", clear_busy, 1);
    for (i = 0; i < 9; i++) begin
      if (i < 8) exp_push(i + 20, 7, 9'(i + 100));
      else n_drop++;
      send(i + 20, 7, 9'(i + 100));
    end
    check("clr_full", fifo_full, 1);
    check("clr_ovf", overflow, 1);
    check("clr_drop_stat", stat_dropped, st(n_drop));
    wait_done("clr_done_seen");
    check("clr_busy_off", clear_busy, 0);
    check("clr_count", clr_next, 19200);
    check("clr_bad", clr_bad, 0);
    exp_push(5, 6, 9'h0EE);
    send(5, 6, 9'h0EE);
    check("full_pop_push", fifo_full, 1);
    check("done_pulse", clear_done, 0);
    check("full_pop_stat", stat_dropped, st(n_drop));
    drain("drain_clr", 20);

    clr_next = 0;
    clr_bad = 0;
    clr_col = 9'h0A5;
    clear_colour = 9'h0A5;
    send(1, 1, 9'h033);
    clear_req = 1'b1;
    exp_push(2, 2, 9'h066);
    send(2, 2, 9'h066);
    clear_req = 1'b0;
    for (i = 0; i < 100; i++) tick();
    clear_colour = 9'h1FF;
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    wait_done("flush_done_seen");
    check("flush_count", clr_next, 19200);
    check("flush_bad", clr_bad, 0);
    drain("drain_flush", 10);
    check("stat_written", stat_written, st(n_wr));
    check("stat_dropped", stat_dropped, st(n_drop));

    clr_next = 0;
    clr_bad = 0;
    clr_col = 9'h111;
    clear_colour = 9'h111;
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    send(3, 3, 9'h001);
    send(4, 4, 9'h002);
    for (i = 0; i < 6000; i++) begin
      if (fb_addr == 15'd5000 && clear_busy) break;
      tick();
    end
    check("abort_at_5000", fb_addr, 5000);
    wr_before = n_wr;
    resetn = 1'b0;
    tick();
    check("abort_wren", fb_wren, 0);
    check("abort_busy", clear_busy, 0);
    check("abort_ovf", overflow, 0);
    check("abort_full", fifo_full, 0);
    check("abort_stw", stat_written, 0);
    resetn = 1'b1;
    for (i = 0; i < 6; i++) tick();
    check("abort_empty", n_wr - wr_before, 0);
    check("abort_done", clear_done, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
